// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares one synchronous FIFO write port among N_REQ
//   valid/ready producers. A requester that wins arbitration may hold the port
//   for up to BURST_LEN consecutive beats. A credit counter mirrors the FIFO
//   free space so that no write is ever issued into a full FIFO. The FIFO write
//   strobe and write data come straight from registers.
//
// Ports
//   clk          : clock
//   hw_rst       : asynchronous active-low reset
//   sw_rst       : synchronous active-low soft clear (pulsed with the FIFO soft reset)
//   req_valid    : per-requester data valid
//   req_last     : per-requester last beat of the current burst
//   req_data     : requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    : per-requester accept (combinational)
//   fifo_wr_en   : registered FIFO write strobe
//   fifo_wr_data : registered FIFO write data
//   fifo_rd_pop  : one FIFO entry was freed this cycle
//   credits      : free FIFO entries as seen by the arbiter
//   grant_id     : current / last owner index
//   busy         : high while a burst holds the port (LOCK state)
//   credit_err   : sticky, a pop arrived while credits were already full

module fifo_wr_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          hw_rst,
  input  logic                          sw_rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0]              req_last,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_rd_pop,
  output logic [ADDR_WIDTH:0]           credits,
  output logic [$clog2(N_REQ)-1:0]      grant_id,
  output logic                          busy,
  output logic                          credit_err
);

  localparam int unsigned ID_W   = $clog2(N_REQ);
  localparam int unsigned CRED_W = ADDR_WIDTH + 1;
  localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // State and datapath registers
  state_t                r_state;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [ID_W-1:0]       r_grant_id;
  logic [BEAT_W-1:0]     r_beat_cnt;
  logic [CRED_W-1:0]     r_credits;
  logic                  r_wr_en;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_credit_err;

  // Next-state and combinational signals
  state_t                w_state_nxt;
  logic [ID_W-1:0]       w_rr_ptr_nxt;
  logic [ID_W-1:0]       w_grant_id_nxt;
  logic [BEAT_W-1:0]     w_beat_cnt_nxt;
  logic [CRED_W-1:0]     w_credits_nxt;
  logic                  w_credit_err_nxt;
  logic [N_REQ-1:0]      w_ready;
  logic [N_REQ-1:0]      w_ready_gated;
  logic                  w_accept;
  logic [ID_W-1:0]       w_sel;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [ID_W-1:0]       w_cand;
  logic [ID_W-1:0]       w_winner;
  logic                  w_winner_vld;
  logic                  w_cred_ok;
  logic                  w_cred_full;
  logic                  w_pop_ok;

  // Round-robin search: first valid requester after rr_ptr, wrapping modulo N_REQ
  always_comb begin : p_winner
    w_cand       = '0;
    w_winner     = '0;
    w_winner_vld = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_cand = ID_W'((32'(r_rr_ptr) + k) % N_REQ);
      if (!w_winner_vld && req_valid[w_cand]) begin
        w_winner     = w_cand;
        w_winner_vld = 1'b1;
      end
    end
  end

  assign w_cred_ok   = (r_credits != '0);
  assign w_cred_full = (r_credits == CRED_W'(DEPTH));

  // Arbitration FSM: next state, pointer, ownership, beat count and readies
  always_comb begin : p_fsm_nxt
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_grant_id_nxt = r_grant_id;
    w_beat_cnt_nxt = r_beat_cnt;
    w_ready        = '0;
    w_sel          = r_grant_id;

    case (r_state)
      ST_ARB: begin
        if (w_winner_vld && w_cred_ok) begin
          w_ready[w_winner] = 1'b1;
          w_sel             = w_winner;
          w_grant_id_nxt    = w_winner;
          w_beat_cnt_nxt    = BEAT_W'(1);
          if (req_last[w_winner] || (BURST_LEN == 1)) begin
            w_rr_ptr_nxt = w_winner;
          end else begin
            w_state_nxt = ST_LOCK;
          end
        end
      end

      ST_LOCK: begin
        if (!req_valid[r_grant_id]) begin
          // Owner went idle mid-burst: release rather than hold a bubble
          w_state_nxt  = ST_ARB;
          w_rr_ptr_nxt = r_grant_id;
        end else if (w_cred_ok) begin
          w_ready[r_grant_id] = 1'b1;
          w_beat_cnt_nxt      = r_beat_cnt + BEAT_W'(1);
          if (req_last[r_grant_id] || ((32'(r_beat_cnt) + 32'd1) == BURST_LEN)) begin
            w_state_nxt  = ST_ARB;
            w_rr_ptr_nxt = r_grant_id;
          end
        end
        // credits==0 with valid owner: stall, keep ownership and beat count
      end

      default: begin
        w_state_nxt = ST_ARB;
      end
    endcase
  end

  // Readies are held low while the hard reset is asserted
  assign w_ready_gated = w_ready & {N_REQ{hw_rst}};
  assign w_accept      = |(req_valid & w_ready_gated);

  // Data of the accepted requester
  always_comb begin : p_data_mux
    w_sel_data = req_data[32'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Credit accounting: debit at accept, credit on pop, saturate at DEPTH
  always_comb begin : p_credit_nxt
    w_pop_ok         = fifo_rd_pop && !w_cred_full;
    w_credits_nxt    = r_credits - CRED_W'(w_accept) + CRED_W'(w_pop_ok);
    w_credit_err_nxt = r_credit_err | (fifo_rd_pop & w_cred_full);
  end

  // State register with async hard reset and sync soft clear
  always_ff @(posedge clk or negedge hw_rst) begin : p_regs
    if (!hw_rst) begin
      r_state      <= ST_ARB;
      r_rr_ptr     <= ID_W'(N_REQ - 1);
      r_grant_id   <= '0;
      r_beat_cnt   <= '0;
      r_credits    <= CRED_W'(DEPTH);
      r_wr_en      <= 1'b0;
      r_wr_data    <= '0;
      r_credit_err <= 1'b0;
    end else if (!sw_rst) begin
      r_state      <= ST_ARB;
      r_rr_ptr     <= ID_W'(N_REQ - 1);
      r_grant_id   <= '0;
      r_beat_cnt   <= '0;
      r_credits    <= CRED_W'(DEPTH);
      r_wr_en      <= 1'b0;
      r_wr_data    <= '0;
      r_credit_err <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_grant_id   <= w_grant_id_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
      r_credits    <= w_credits_nxt;
      r_wr_en      <= w_accept;
      r_wr_data    <= w_accept ? w_sel_data : r_wr_data;
      r_credit_err <= w_credit_err_nxt;
    end
  end

  assign req_ready    = w_ready_gated;
  assign fifo_wr_en   = r_wr_en;
  assign fifo_wr_data = r_wr_data;
  assign credits      = r_credits;
  assign grant_id     = r_grant_id;
  assign busy         = (r_state == ST_LOCK);
  assign credit_err   = r_credit_err;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Scenario tasks drive the requesters and push the data each expected accept
//   should carry into a queue; a negedge monitor pops and compares every FIFO
//   write. Tasks also check readies, credits, ownership and flags inline.

module tb_fifo_wr_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned BL    = 4;

  logic              clk;
  logic              hw_rst;
  logic              sw_rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_last;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_wr_data;
  logic              fifo_rd_pop;
  logic [AW:0]       credits;
  logic [1:0]        grant_id;
  logic              busy;
  logic              credit_err;

  int                n_checks;
  int                n_fail;
  logic [DW-1:0]     exp_q[$];
  logic [DW-1:0]     mon_exp;

  fifo_wr_arbiter #(
    .N_REQ(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .hw_rst(hw_rst), .sw_rst(sw_rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_rd_pop(fifo_rd_pop), .credits(credits), .grant_id(grant_id),
    .busy(busy), .credit_err(credit_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard monitor for FIFO writes
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected got_data=%h required=no_write", fifo_wr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (fifo_wr_data !== mon_exp) begin
          n_fail++;
          $display("FAIL wr_data got=%h required=%h", fifo_wr_data, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    hw_rst = 1'b0; sw_rst = 1'b1; fifo_rd_pop = 1'b0;
    req_valid = '1; req_last = '1; req_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready got=%b required=0000", req_ready); end
    n_checks++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en got=%b required=0", fifo_wr_en); end
    n_checks++; if (fifo_wr_data !== '0) begin n_fail++; $display("FAIL rst_wr_data got=%h required=0", fifo_wr_data); end
    n_checks++; if (credits !== 6'd32) begin n_fail++; $display("FAIL rst_credits got=%0d required=32", credits); end
    n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_grant_id got=%0d required=0", grant_id); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b required=0", busy); end
    n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL rst_credit_err got=%b required=0", credit_err); end
    tick();
    req_valid = '0;
    hw_rst = 1'b1;
  endtask

  task automatic test_round_robin();
    int w;
    req_valid = '1; req_last = '1;
    for (int n = 0; n < 32; n++) begin
      w = n % 4;
      for (int i = 0; i < 4; i++) set_data(i, {16'(i), 16'(n)});
      exp_q.push_back({16'(w), 16'(n)});
      @(negedge clk);
      n_checks++; if (req_ready !== 4'(1 << w)) begin n_fail++; $display("FAIL rr_ready n=%0d got=%b required=%b", n, req_ready, 4'(1 << w)); end
      n_checks++; if (credits !== 6'(32 - n)) begin n_fail++; $display("FAIL rr_credits n=%0d got=%0d required=%0d", n, credits, 32 - n); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_busy n=%0d got=%b required=0", n, busy); end
      if (n > 0) begin
        n_checks++; if (grant_id !== 2'((n - 1) % 4)) begin n_fail++; $display("FAIL rr_grant_id n=%0d got=%0d required=%0d", n, grant_id, (n - 1) % 4); end
      end
      tick();
    end
    @(negedge clk);
    n_checks++; if (credits !== 6'd0) begin n_fail++; $display("FAIL rr_credits_empty got=%0d required=0", credits); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_ready_nocredit got=%b required=0000", req_ready); end
    n_checks++; if (grant_id !== 2'd3) begin n_fail++; $display("FAIL rr_last_grant got=%0d required=3", grant_id); end
    tick();
    req_valid = '0;
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_pending_writes got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_credit_zero();
    req_valid = 4'b0010; req_last = '1;
    set_data(1, 32'hC0DE_0001);
    fifo_rd_pop = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL cz_ready_before got=%b required=0000", req_ready); end
    n_checks++; if (credits !== 6'd0) begin n_fail++; $display("FAIL cz_credits_before got=%0d required=0", credits); end
    tick();
    fifo_rd_pop = 1'b0;
    exp_q.push_back(32'hC0DE_0001);
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL cz_ready_after_pop got=%b required=0010", req_ready); end
    n_checks++; if (credits !== 6'd1) begin n_fail++; $display("FAIL cz_credits_after_pop got=%0d required=1", credits); end
    tick();
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL cz_ready_again got=%b required=0000", req_ready); end
    n_checks++; if (credits !== 6'd0) begin n_fail++; $display("FAIL cz_credits_again got=%0d required=0", credits); end
    n_checks++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL cz_grant_id got=%0d required=1", grant_id); end
    tick();
    req_valid = '0;
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL cz_pending_writes got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_refill();
    for (int k = 0; k < 32; k++) begin
      fifo_rd_pop = 1'b1;
      tick();
    end
    fifo_rd_pop = 1'b0;
    @(negedge clk);
    n_checks++; if (credits !== 6'd32) begin n_fail++; $display("FAIL refill_credits got=%0d required=32", credits); end
    n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL refill_credit_err got=%b required=0", credit_err); end
    tick();
  endtask

  task automatic test_burst();
    int exp_gnt  [8];
    int exp_busy [9];
    int exp_gid  [9];
    int b2;
    int b3;
    exp_gnt  = '{2, 2, 2, 2, 3, 3, 2, 2};
    exp_busy = '{0, 1, 1, 1, 0, 1, 0, 1, 0};
    exp_gid  = '{1, 2, 2, 2, 2, 3, 3, 2, 2};
    b2 = 0; b3 = 0;
    for (int c = 0; c < 9; c++) begin
      req_valid = {(b3 < 2), (b2 < 6), 2'b00};
      req_last  = {(b3 == 1), (b2 == 5), 2'b00};
      set_data(2, {16'h2222, 16'(b2)});
      set_data(3, {16'h3333, 16'(b3)});
      if (c < 8) begin
        if (exp_gnt[c] == 2) begin exp_q.push_back({16'h2222, 16'(b2)}); b2++; end
        else                 begin exp_q.push_back({16'h3333, 16'(b3)}); b3++; end
      end
      @(negedge clk);
      if (c < 8) begin
        n_checks++; if (req_ready !== 4'(1 << exp_gnt[c])) begin n_fail++; $display("FAIL burst_ready c=%0d got=%b required=%b", c, req_ready, 4'(1 << exp_gnt[c])); end
      end else begin
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL burst_ready_idle got=%b required=0000", req_ready); end
      end
      n_checks++; if (busy !== 1'(exp_busy[c])) begin n_fail++; $display("FAIL burst_busy c=%0d got=%b required=%0d", c, busy, exp_busy[c]); end
      n_checks++; if (grant_id !== 2'(exp_gid[c])) begin n_fail++; $display("FAIL burst_grant_id c=%0d got=%0d required=%0d", c, grant_id, exp_gid[c]); end
      tick();
    end
    req_valid = '0; req_last = '0;
    @(negedge clk);
    n_checks++; if (credits !== 6'd24) begin n_fail++; $display("FAIL burst_credits got=%0d required=24", credits); end
    tick();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL burst_pending_writes got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_accept_pop();
    req_valid = 4'b0001; req_last = '1;
    for (int k = 0; k < 14; k++) begin
      set_data(0, 32'hA5A5_0000 | 32'(k));
      exp_q.push_back(32'hA5A5_0000 | 32'(k));
      @(negedge clk);
      n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL ap_ready k=%0d got=%b required=0001", k, req_ready); end
      tick();
    end
    set_data(0, 32'hA5A5_00FF);
    exp_q.push_back(32'hA5A5_00FF);
    fifo_rd_pop = 1'b1;
    @(negedge clk);
    n_checks++; if (credits !== 6'd10) begin n_fail++; $display("FAIL ap_credits_before got=%0d required=10", credits); end
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL ap_ready_pop got=%b required=0001", req_ready); end
    tick();
    fifo_rd_pop = 1'b0;
    req_valid = '0;
    @(negedge clk);
    n_checks++; if (credits !== 6'd10) begin n_fail++; $display("FAIL ap_credits_after got=%0d required=10", credits); end
    tick();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ap_pending_writes got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_pop_full();
    for (int k = 0; k < 22; k++) begin
      fifo_rd_pop = 1'b1;
      tick();
    end
    @(negedge clk);
    n_checks++; if (credits !== 6'd32) begin n_fail++; $display("FAIL pf_credits_full got=%0d required=32", credits); end
    n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL pf_err_before got=%b required=0", credit_err); end
    tick();
    fifo_rd_pop = 1'b0;
    @(negedge clk);
    n_checks++; if (credits !== 6'd32) begin n_fail++; $display("FAIL pf_credits_sat got=%0d required=32", credits); end
    n_checks++; if (credit_err !== 1'b1) begin n_fail++; $display("FAIL pf_err_set got=%b required=1", credit_err); end
    repeat (3) tick();
    @(negedge clk);
    n_checks++; if (credit_err !== 1'b1) begin n_fail++; $display("FAIL pf_err_sticky got=%b required=1", credit_err); end
    tick();
    sw_rst = 1'b0;
    tick();
    sw_rst = 1'b1;
    @(negedge clk);
    n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL pf_err_swrst got=%b required=0", credit_err); end
    n_checks++; if (credits !== 6'd32) begin n_fail++; $display("FAIL pf_credits_swrst got=%0d required=32", credits); end
    tick();
  endtask

  task automatic test_hw_rst_mid_burst();
    req_valid = 4'b0010; req_last = '0;
    set_data(1, 32'hB0B0_0001);
    exp_q.push_back(32'hB0B0_0001);
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL hr_ready_b1 got=%b required=0010", req_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hr_busy_b1 got=%b required=0", busy); end
    tick();
    set_data(1, 32'hB0B0_0002);
    exp_q.push_back(32'hB0B0_0002);
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL hr_ready_b2 got=%b required=0010", req_ready); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hr_busy_b2 got=%b required=1", busy); end
    tick();
    n_checks++; if (fifo_wr_en !== 1'b1) begin n_fail++; $display("FAIL hr_wr_pending got=%b required=1", fifo_wr_en); end
    #2;
    hw_rst = 1'b0;
    #1;
    n_checks++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL hr_wr_en_cleared got=%b required=0", fifo_wr_en); end
    n_checks++; if (credits !== 6'd32) begin n_fail++; $display("FAIL hr_credits got=%0d required=32", credits); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hr_busy got=%b required=0", busy); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL hr_ready_in_reset got=%b required=0000", req_ready); end
    n_checks++; if (exp_q.size() != 1) begin n_fail++; $display("FAIL hr_queue_depth got=%0d required=1", exp_q.size()); end
    exp_q.delete();
    tick();
    hw_rst = 1'b1;
    req_valid = 4'b0011; req_last = '1;
    set_data(0, 32'hD000_0000);
    set_data(1, 32'hD000_0001);
    exp_q.push_back(32'hD000_0000);
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL hr_restart_ready got=%b required=0001", req_ready); end
    n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL hr_restart_gid got=%0d required=0", grant_id); end
    tick();
    exp_q.push_back(32'hD000_0001);
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL hr_next_ready got=%b required=0010", req_ready); end
    n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL hr_next_gid got=%0d required=0", grant_id); end
    tick();
    req_valid = '0;
    @(negedge clk);
    n_checks++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL hr_final_gid got=%0d required=1", grant_id); end
    tick();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL hr_pending_writes got=%0d required=0", exp_q.size()); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_round_robin();
    test_credit_zero();
    test_refill();
    test_burst();
    test_accept_pop();
    test_pop_full();
    test_hw_rst_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
